store_ecc_encoder: RTL and testbench
====================================

# store_ecc_encoder

Store-side DEC-TED encoder. Accepts a 32-bit store word over a valid/ready handshake and computes the 16-bit check field consumed by the load-side decoder (`load_module`). The check field is a shortened binary BCH(63,51) remainder plus an overall parity bit, computed serially at a configurable number of data bits per cycle. It then presents {data, parity} to the memory write port over a second valid/ready handshake. An optional error-injection mask is captured with each word so the load path can be exercised with known 1/2/3-bit faults.

## Interface
- `BITS_PER_CYCLE`, default 4: data bits folded into the remainder per clock; legal values 1, 2, 4, 8, 16, 32. N = 32/BITS_PER_CYCLE.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  store word offered
- `in_ready`  out  1  encoder can accept
- `in_data`  in  32  store data
- `in_inj_mask`  in  48  error-injection mask; [31:0] applies to data, [47:32] applies to parity
- `out_valid`  out  1  encoded word available
- `out_ready`  in  1  write port accepts
- `out_data`  out  32  stored data XOR captured mask[31:0]
- `out_parity`  out  16  check field XOR captured mask[47:32]

## Operation
- **Code**
  - g(x) = x^12+x^10+x^8+x^5+x^4+x^3+1 (0x1539). This is m1·m3 over GF(2^6) with primitive polynomial x^6+x+1.
  - p[11:0] = (d(x)·x^12) mod g(x). d(x) has data[31] as the x^31 coefficient.
  - p[12] = XOR of data[31:0] and p[11:0], so the 45-bit codeword has even weight.
  - p[15:13] = 0.
- **Serial LFSR**, 12-bit register r, data processed MSB first. For each bit b: fb = b ^ r[11]; r = {r[10:0],1'b0} ^ (fb ? 12'h539 : 0).
  - BITS_PER_CYCLE bits are folded per clock, as an unrolled chain of that step.
  - Overall parity is accumulated alongside.
- **FSM states**: IDLE, SHIFT, DONE.
  - IDLE:
    - in_ready=1, out_valid=0.
    - On in_valid: capture in_data into a shift register and into the data output register, capture in_inj_mask, clear r, the parity accumulator and the beat counter, then go to SHIFT.
  - SHIFT:
    - in_ready=0. Fold the top BITS_PER_CYCLE bits of the shift register, shift left, increment the counter.
    - On the N-th beat, go to DONE and register out_parity = {3'b0, accP, r_next} ^ mask[47:32].
  - DONE:
    - out_valid=1, outputs held stable.
    - On out_ready, go to IDLE.
    - in_ready stays 0 in DONE. There is no same-cycle turnaround.
- The mask is applied only at the outputs. Encoding always uses the clean in_data.
- Inputs are ignored outside IDLE.

## Timing
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, out_data=0, out_parity=0, r=0, counter=0.
- Latency:
  - Accept on edge k; out_valid is first high after edge k+N.
  - BITS_PER_CYCLE=32: out_valid high one cycle after acceptance. BITS_PER_CYCLE=4: eight cycles after acceptance.
- Throughput: at most one word per N+2 cycles when out_ready is held high.
- Backpressure: out_valid, out_data and out_parity are held without change while out_ready=0, for any number of cycles.
- Handshakes:
  - in_valid may drop without acceptance; no state changes.
  - in_ready never depends on out_ready.
- Reset: rst_n=0 on any edge, including mid-SHIFT or in DONE, discards the word and restores reset values on that edge.
- The counter wraps only through the transition to DONE. No beat beyond N is processed.

## Test plan
- **Reset mid-operation, BITS_PER_CYCLE=4**: reset, then accept in_data=0x0000_0000 with mask 0 → out_valid after 8 cycles, out_data=0x00000000, out_parity=0x0000.
- **Single-bit data values**:
  - in_data=0x00000001 → out_parity=0x1539.
  - in_data=0x00000002 → out_parity=0x1A72.
  - Checked at BITS_PER_CYCLE=1, 4 and 32 (latency 32, 8, 1).
- **Random sweep**: 10k random words at every legal BITS_PER_CYCLE → out_parity equals the bit-serial reference model. Feeding {out_data, out_parity} into `load_module` gives corrected_data==in_data with no error flags.
- **Error injection**:
  - in_data=0, mask[31:0]=0x1 → out_data=0x1, out_parity=0x0000; decoder flags a single error.
  - mask[31:0]=0x5 → decoder flags a double error.
  - mask[31:0]=0x7 → decoder asserts triple_error.
- **Backpressure**: hold out_ready=0 for 20 cycles in DONE → outputs stable, in_ready=0, a second in_valid is not accepted. Release → next word is accepted only after the return to IDLE.
- **Reset mid-SHIFT**: assert rst_n=0 on beat 3 of 8 → next cycle in_ready=1, out_valid=0, out_parity=0. A following word encodes correctly.

Source files
------------

// File: rtl/store_ecc_encoder.sv
// Store-side DEC-TED encoder. Computes a shortened BCH(63,51) remainder plus an overall
// parity bit over a 32-bit store word, folding BITS_PER_CYCLE data bits per clock, and
// presents {data, parity} (optionally corrupted by a captured injection mask) downstream.
module store_ecc_encoder #(
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [47:0] in_inj_mask,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [15:0] out_parity
);

    // g(x) = x^12+x^10+x^8+x^5+x^4+x^3+1 with the x^12 term implied by the feedback
    localparam logic [11:0] Poly    = 12'h539;
    localparam int unsigned Beats   = 32 / BITS_PER_CYCLE;
    localparam int unsigned CntW    = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     shift_q, shift_next;
    logic [11:0]     r_q, r_next;
    logic            acc_q, acc_next;
    logic [CntW-1:0] cnt_q;
    logic [15:0]     mask_q;
    logic [31:0]     out_data_q;
    logic [15:0]     out_parity_q;
    logic            accept;
    logic            last_beat;

    // Fold the top BITS_PER_CYCLE bits of the shift register through the bit-serial LFSR step
    always_comb begin
        logic b;
        logic fb;
        b          = 1'b0;
        fb         = 1'b0;
        r_next     = r_q;
        acc_next   = acc_q;
        shift_next = shift_q;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            b          = shift_next[31];
            fb         = b ^ r_next[11];
            r_next     = {r_next[10:0], 1'b0} ^ (fb ? Poly : 12'h000);
            acc_next   = acc_next ^ b;
            shift_next = {shift_next[30:0], 1'b0};
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        last_beat = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q == LastCnt) begin
                    last_beat = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: capture on accept, fold while shifting, latch the check field on the last beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q      <= '0;
            r_q          <= '0;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            mask_q       <= '0;
            out_data_q   <= '0;
            out_parity_q <= '0;
        end else if (accept) begin
            shift_q    <= in_data;
            r_q        <= '0;
            acc_q      <= 1'b0;
            cnt_q      <= '0;
            mask_q     <= in_inj_mask[47:32];
            // The mask only corrupts what leaves the block; encoding uses the clean word
            out_data_q <= in_data ^ in_inj_mask[31:0];
        end else if (state_q == StShift) begin
            shift_q <= shift_next;
            r_q     <= r_next;
            acc_q   <= acc_next;
            cnt_q   <= last_beat ? '0 : cnt_q + 1'b1;
            if (last_beat) begin
                // Overall parity covers data and the 12 BCH bits so the codeword has even weight
                out_parity_q <= {3'b000, acc_next ^ (^r_next), r_next} ^ mask_q;
            end
        end
    end

    assign out_data   = out_data_q;
    assign out_parity = out_parity_q;

endmodule

// File: tb/tb_store_ecc_encoder.sv
// Directed bench for store_ecc_encoder at BITS_PER_CYCLE = 4, 1 and 32.
module tb_store_ecc_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [47:0] in_inj_mask;
    logic        out_ready;

    // DUT select: 0 -> BITS_PER_CYCLE=4, 1 -> 1, 2 -> 32
    int unsigned sel;

    logic        in_ready_a, in_ready_b, in_ready_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [31:0] out_data_a, out_data_b, out_data_c;
    logic [15:0] out_parity_a, out_parity_b, out_parity_c;

    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [15:0] out_parity;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    store_ecc_encoder #(.BITS_PER_CYCLE(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(in_ready_a),
        .in_data(in_data), .in_inj_mask(in_inj_mask), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_parity(out_parity_a)
    );

    store_ecc_encoder #(.BITS_PER_CYCLE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(in_ready_b),
        .in_data(in_data), .in_inj_mask(in_inj_mask), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_parity(out_parity_b)
    );

    store_ecc_encoder #(.BITS_PER_CYCLE(32)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(in_ready_c),
        .in_data(in_data), .in_inj_mask(in_inj_mask), .out_valid(out_valid_c),
        .out_ready(out_ready), .out_data(out_data_c), .out_parity(out_parity_c)
    );

    always_comb begin
        in_ready   = in_ready_a;
        out_valid  = out_valid_a;
        out_data   = out_data_a;
        out_parity = out_parity_a;
        if (sel == 1) begin
            in_ready   = in_ready_b;
            out_valid  = out_valid_b;
            out_data   = out_data_b;
            out_parity = out_parity_b;
        end else if (sel == 2) begin
            in_ready   = in_ready_c;
            out_valid  = out_valid_c;
            out_data   = out_data_c;
            out_parity = out_parity_c;
        end
    end

    // Reference: long division of d(x)*x^12 by g(x), then overall even parity in bit 12
    function automatic logic [15:0] ref_parity(input logic [31:0] d);
        logic [43:0] v;
        logic [12:0] g;
        g = 13'h1539;
        v = {d, 12'h000};
        for (int i = 43; i >= 12; i--) begin
            if (v[i]) v[i -: 13] = v[i -: 13] ^ g;
        end
        return {3'b000, (^d) ^ (^v[11:0]), v[11:0]};
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word, measure latency to out_valid, check outputs, then drain it
    task automatic encode(input string tag, input logic [31:0] d, input logic [47:0] m,
                          input logic [31:0] exp_d, input logic [15:0] exp_p,
                          input int exp_lat);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 100) begin
            step();
            w++;
        end
        check({tag, " in_ready"}, in_ready, 1'b1);
        in_valid    = 1'b1;
        in_data     = d;
        in_inj_mask = m;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " data"}, out_data, exp_d);
        check({tag, " parity"}, out_parity, exp_p);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rw;
        logic [31:0] held_d;
        logic [15:0] held_p;
        logic        stable;
        logic        never_ready;
        int          w;

        sel         = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_inj_mask = '0;
        out_ready   = 1'b0;
        step();
        step();
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_data", out_data, 32'h0);
        check("reset out_parity", out_parity, 16'h0);
        rst_n = 1'b1;
        step();

        // Hand-computed vectors at 4 bits/cycle; 0x3 follows from linearity of 0x1 and 0x2
        encode("bpc4 zero", 32'h0, 48'h0, 32'h0, 16'h0000, 8);
        encode("bpc4 d1", 32'h1, 48'h0, 32'h1, 16'h1539, 8);
        encode("bpc4 d2", 32'h2, 48'h0, 32'h2, 16'h1A72, 8);
        encode("bpc4 d3", 32'h3, 48'h0, 32'h3, 16'h0F4B, 8);

        sel = 1;
        encode("bpc1 d1", 32'h1, 48'h0, 32'h1, 16'h1539, 32);
        encode("bpc1 d2", 32'h2, 48'h0, 32'h2, 16'h1A72, 32);
        sel = 2;
        encode("bpc32 d1", 32'h1, 48'h0, 32'h1, 16'h1539, 1);
        encode("bpc32 d2", 32'h2, 48'h0, 32'h2, 16'h1A72, 1);

        // Error injection: mask hits outputs only
        sel = 0;
        encode("inj d0", 32'h0, 48'h1, 32'h1, 16'h0000, 8);
        encode("inj d5", 32'h0, 48'h5, 32'h5, 16'h0000, 8);
        encode("inj d7", 32'h0, 48'h7, 32'h7, 16'h0000, 8);
        encode("inj par", 32'h1, 48'h0001_0000_0000, 32'h1, 16'h1538, 8);

        // Random words against the division model on every instance
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int k = 0; k < 4; k++) begin
                rw = $urandom;
                encode("rand", rw, 48'h0, rw, ref_parity(rw), (s == 0) ? 8 : (s == 1) ? 32 : 1);
            end
        end

        // Backpressure: hold DONE for 20 cycles while a second word is offered
        sel         = 0;
        in_valid    = 1'b1;
        in_data     = 32'h2;
        in_inj_mask = '0;
        step();
        in_data = 32'h1;
        w = 0;
        while (!out_valid && w < 100) begin
            step();
            w++;
        end
        check("bp first valid", out_valid, 1'b1);
        held_d      = out_data;
        held_p      = out_parity;
        stable      = 1'b1;
        never_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (!out_valid || out_data !== held_d || out_parity !== held_p) stable = 1'b0;
            if (in_ready) never_ready = 1'b0;
        end
        check("bp stable", stable, 1'b1);
        check("bp in_ready low", never_ready, 1'b1);
        check("bp held parity", held_p, 16'h1A72);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp back idle", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin
            step();
            w++;
        end
        check("bp second latency", w, 8);
        check("bp second parity", out_parity, 16'h1539);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset on beat 3 of 8
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst mid in_ready", in_ready, 1'b1);
        check("rst mid out_valid", out_valid, 1'b0);
        check("rst mid out_parity", out_parity, 16'h0);
        check("rst mid out_data", out_data, 32'h0);
        encode("after rst", 32'h1, 48'h0, 32'h1, 16'h1539, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
